// File: rtl/spmv_result_wb.sv
// Writes a captured 16-word SpMV result vector to memory, one word per accepted write.
// Optional feature: define SPMV_WB_SKIP_ZERO_EN to skip words equal to zero.
module spmv_result_wb #(
  parameter int ADDR_W  = 8,
  parameter int N_WORDS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [16*N_WORDS-1:0]   i_result,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic                    i_wr_ready,
  output logic                    o_wr_en,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [15:0]             o_wr_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4:0]              o_wr_count
);

`ifdef SPMV_WB_SKIP_ZERO_EN
  localparam logic SKIP_ZERO = 1'b1;
`else
  localparam logic SKIP_ZERO = 1'b0;
`endif

  localparam logic [3:0] LAST_K = 4'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [16*N_WORDS-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [3:0]              k_q, k_d, k_nxt;
  logic                    wr_en_d, busy_d, done_d, transfer;
  logic [ADDR_W-1:0]       addr_d;
  logic [15:0]             data_d;
  logic [4:0]              count_d;

  function automatic logic [15:0] word_at(input logic [16*N_WORDS-1:0] vec,
                                          input logic [3:0] idx);
    return vec[idx*16 +: 16];
  endfunction

  // A word gets a write request unless zero-skipping is enabled and it is zero.
  function automatic logic needs_write(input logic [15:0] w);
    return !SKIP_ZERO || (w != 16'h0000);
  endfunction

  assign k_nxt    = k_q + 4'd1;
  assign transfer = o_wr_en & i_wr_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    base_d   = base_q;
    k_d      = k_q;
    count_d  = o_wr_count;
    wr_en_d  = o_wr_en;
    addr_d   = o_wr_addr;
    data_d   = o_wr_data;
    busy_d   = o_busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = WRITE;
          result_d = i_result;
          base_d   = i_base_addr;
          k_d      = 4'd0;
          count_d  = 5'd0;
          wr_en_d  = needs_write(word_at(i_result, 4'd0));
          addr_d   = i_base_addr;
          data_d   = word_at(i_result, 4'd0);
          busy_d   = 1'b1;
        end
      end
      WRITE: begin
        // A word is disposed of either by an accepted write or by a skip cycle.
        if (transfer || !o_wr_en) begin
          if (transfer) count_d = o_wr_count + 5'd1;
          if (k_q == LAST_K) begin
            state_d = DONE;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d     = k_nxt;
            wr_en_d = needs_write(word_at(result_q, k_nxt));
            addr_d  = base_q + ADDR_W'(k_nxt);
            data_d  = word_at(result_q, k_nxt);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      result_q   <= '0;
      base_q     <= '0;
      k_q        <= '0;
      o_wr_count <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      base_q     <= base_d;
      k_q        <= k_d;
      o_wr_count <= count_d;
      o_wr_en    <= wr_en_d;
      o_wr_addr  <= addr_d;
      o_wr_data  <= data_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_spmv_result_wb.sv
// Bench for spmv_result_wb: directed and randomized write-back jobs against a list-based model.
module tb_spmv_result_wb;

`ifdef SPMV_WB_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk;
  logic         i_rst, i_start, i_wr_ready;
  logic [255:0] i_result;
  logic [7:0]   i_base_addr;
  logic         o_wr_en, o_busy, o_done;
  logic [7:0]   o_wr_addr;
  logic [15:0]  o_wr_data;
  logic [4:0]   o_wr_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_k[$];

  spmv_result_wb #(.ADDR_W(8), .N_WORDS(16)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_result   (i_result),
    .i_base_addr(i_base_addr),
    .i_wr_ready (i_wr_ready),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_wr_count (o_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write list: every word in order, minus zero words when skipping.
  task automatic build_exp(input logic [255:0] res, input logic [7:0] base);
    logic [15:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_k.delete();
    for (int k = 0; k < 16; k++) begin
      w = res[k*16 +: 16];
      if (!(SKIP && w == 16'h0000)) begin
        exp_addr.push_back(8'(int'(base) + k));
        exp_data.push_back(w);
        exp_k.push_back(k);
      end
    end
  endtask

  task automatic run_job(input logic [255:0] res, input logic [7:0] base,
                         input int stall_k, input int stall_n, input int rst_cyc,
                         input bit extra, input bit rand_ready);
    int nwr, nstall, stall_left, done_cyc, first_wr;
    bit prev_stall;
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;
    build_exp(res, base);
    nwr = 0; nstall = 0; stall_left = stall_n; done_cyc = -1; first_wr = -1;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    @(negedge clk);
    i_start = 1'b1; i_result = res; i_base_addr = base; i_wr_ready = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_rst = 1'b0;
      i_result = {8{$urandom()}};
      i_base_addr = 8'($urandom());
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_count", 32'(o_wr_count), 0);
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          check("abort_no_done", 32'(o_done), 0);
          check("abort_no_wr", 32'(o_wr_en), 0);
        end
        return;
      end
      if (o_done) begin
        done_cyc = c;
        if (extra && c == 17) i_start = 1'b1;
        break;
      end
      check("busy", 32'(o_busy), 1);
      if (prev_stall) begin
        check("hold_en", 32'(o_wr_en), 1);
        check("hold_addr", 32'(o_wr_addr), 32'(prev_addr));
        check("hold_data", 32'(o_wr_data), 32'(prev_data));
      end
      i_wr_ready = 1'b1;
      if (rand_ready) i_wr_ready = ($urandom_range(0, 3) != 0);
      if (o_wr_en && nwr == stall_k && stall_left > 0) begin
        i_wr_ready = 1'b0;
        stall_left--;
      end
      prev_stall = o_wr_en && !i_wr_ready;
      if (o_wr_en) begin
        if (i_wr_ready) begin
          if (first_wr < 0) first_wr = c;
          if (nwr < exp_addr.size()) begin
            check("wr_addr", 32'(o_wr_addr), 32'(exp_addr[nwr]));
            check("wr_data", 32'(o_wr_data), 32'(exp_data[nwr]));
          end
          nwr++;
        end else begin
          nstall++;
        end
        prev_addr = o_wr_addr;
        prev_data = o_wr_data;
      end
      if (extra && c == 4) i_start = 1'b1;
      if (c == rst_cyc) i_rst = 1'b1;
    end
    check("done_cyc", 32'(done_cyc), 32'(17 + nstall));
    check("n_writes", 32'(nwr), 32'(exp_addr.size()));
    check("wr_count", 32'(o_wr_count), 32'(exp_addr.size()));
    check("done_wr_en", 32'(o_wr_en), 0);
    if (!rand_ready && exp_k.size() > 0)
      check("first_wr", 32'(first_wr), 32'(1 + exp_k[0]));
    @(negedge clk);
    i_start = 1'b0;
    check("idle_busy", 32'(o_busy), 0);
    check("idle_done", 32'(o_done), 0);
    check("idle_wr_en", 32'(o_wr_en), 0);
    check("count_hold", 32'(o_wr_count), 32'(exp_addr.size()));
    @(negedge clk);
    check("no_queue_busy", 32'(o_busy), 0);
  endtask

  initial begin
    logic [255:0] seq_vec, even_zero, rnd;
    i_rst = 1'b1; i_start = 1'b0; i_wr_ready = 1'b1;
    i_result = '0; i_base_addr = '0;
    for (int k = 0; k < 16; k++) begin
      seq_vec[k*16 +: 16]   = 16'(k + 1);
      even_zero[k*16 +: 16] = (k % 2 == 0) ? 16'h0000 : 16'(16'h0100 + k);
    end
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(o_wr_en), 0);
    check("reset_addr", 32'(o_wr_addr), 0);
    check("reset_data", 32'(o_wr_data), 0);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_done", 32'(o_done), 0);
    check("reset_count", 32'(o_wr_count), 0);
    i_rst = 1'b0;
    @(negedge clk);

    run_job(seq_vec, 8'h10, -1, 0, -1, 1'b0, 1'b0);
    run_job(seq_vec, 8'hFA, -1, 0, -1, 1'b0, 1'b0);
    run_job(seq_vec, 8'h20, 5, 3, -1, 1'b0, 1'b0);
    run_job(seq_vec, 8'h40, -1, 0, 7, 1'b0, 1'b0);
    run_job(seq_vec, 8'h80, -1, 0, -1, 1'b1, 1'b0);
    run_job(even_zero, 8'h30, -1, 0, -1, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 16; k++)
        rnd[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
      run_job(rnd, 8'($urandom()), -1, 0, -1, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spmv_result_wb.md
SPMV_RESULT_WB -- requirements
Module: spmv_result_wb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the width of the result memory word address.
REQ-002 The block SHALL have parameter N_WORDS, default 16, giving the number of 16-bit words in the result vector; it is fixed at 16 and not overridden.
REQ-003 i_clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  Reset; synchronous, active-high.
REQ-005 i_start  input  1  One-cycle request to write back a result vector; sampled only in IDLE.
REQ-006 i_result  input  256  Result vector from the SpMV core; word k = i_result[16k+15:16k].
REQ-007 i_base_addr  input  ADDR_W  Memory address that receives word 0.
REQ-008 i_wr_ready  input  1  Memory accepts the current write this cycle.
REQ-009 o_wr_en  output  1  A write request is presented.
REQ-010 o_wr_addr  output  ADDR_W  Write address.
REQ-011 o_wr_data  output  16  Write data.
REQ-012 o_busy  output  1  High while in WRITE state.
REQ-013 o_done  output  1  One-cycle pulse on completion.
REQ-014 o_wr_count  output  5  Number of words actually written in the current or last job (0..16).

Function
REQ-015 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-016 Transitions SHALL be: IDLE->WRITE on i_start; WRITE->DONE after word 15 is disposed of; DONE->IDLE unconditionally after one cycle.
REQ-017 On i_start in IDLE, the block SHALL capture i_result and i_base_addr into internal registers, clear o_wr_count, and set word index k=0.
REQ-018 Later changes on i_result or i_base_addr SHALL NOT affect an active job.
REQ-019 In WRITE, the block SHALL present o_wr_en=1, o_wr_data=captured word k and o_wr_addr=(base+k) mod 2^ADDR_W.
REQ-020 A write transfer SHALL occur on a cycle with o_wr_en=1 and i_wr_ready=1.
REQ-021 On a write transfer, k SHALL increment and o_wr_count SHALL increment.
REQ-022 While i_wr_ready=0, o_wr_en, o_wr_addr and o_wr_data SHALL hold stable.
REQ-023 All outputs SHALL be registered.
REQ-024 Latency: with i_start in cycle 0 and i_wr_ready held 1, the first write SHALL occur in cycle 1 and the last write in cycle 16.
REQ-025 In the same case, o_done SHALL be 1 in cycle 17 and the FSM SHALL be back in IDLE in cycle 18.
REQ-026 o_wr_en SHALL be 0 in IDLE and DONE.
REQ-027 o_busy SHALL be 1 exactly in WRITE.
REQ-028 o_done SHALL be 1 exactly in DONE.
REQ-029 i_start SHALL be ignored in WRITE and DONE; it does not queue a job.
REQ-030 Address generation SHALL wrap modulo 2^ADDR_W without error.
REQ-031 o_wr_count SHALL hold its final value until the next accepted i_start.

Reset
REQ-032 When i_rst=1 at a clock edge, in any state, the FSM SHALL go to IDLE.
REQ-033 Reset SHALL clear o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_wr_count, k and the captured registers to 0.
REQ-034 A reset mid-job SHALL abort the job: no further write, and no o_done pulse.
REQ-035 i_rst SHALL take priority over i_start in the same cycle.

Configuration
REQ-036 Macro SPMV_WB_SKIP_ZERO_EN SHALL control zero-word skipping.
REQ-037 If SPMV_WB_SKIP_ZERO_EN is defined, a captured word equal to 16'h0000 SHALL be skipped: for one WRITE cycle o_wr_en=0, then k increments regardless of i_wr_ready and o_wr_count is unchanged.
REQ-038 If SPMV_WB_SKIP_ZERO_EN is not defined, all 16 words SHALL be written, including zero words.
REQ-039 Timing of o_done relative to i_start SHALL be identical with and without the macro when i_wr_ready=1.

Verification
REQ-040 The bench SHALL cover: i_result words k=k+1, base=8'h10, i_wr_ready=1 -> writes addr 0x10..0x1F with data 1..16 in cycles 1..16, o_done in cycle 17, o_wr_count=16.
REQ-041 The bench SHALL cover: base=8'hFA, ADDR_W=8 -> addresses 0xFA..0xFF then 0x00..0x09.
REQ-042 The bench SHALL cover: i_wr_ready low for 3 cycles on word 5 -> addr/data held for 3 cycles, o_done delayed to cycle 20.
REQ-043 The bench SHALL cover: i_rst=1 in cycle 7 -> cycle 8 o_wr_en=0, IDLE, no o_done, o_wr_count=0.
REQ-044 The bench SHALL cover: i_start pulsed in cycles 4 and 17 -> both ignored; exactly 16 writes occur.
REQ-045 The bench SHALL cover, with SPMV_WB_SKIP_ZERO_EN defined: even-indexed words zero -> 8 writes at odd addresses only, o_wr_count=8, o_done in cycle 17.
